f_fetch_ctrl: RTL
=================

Name: f_fetch_ctrl

Overview:
- Fetch-stage sequencer for the 5-stage MIPS pipeline.
- Owns the F-stage PC register and the next-fetch-address register (npc).
- Issues requests to a variable-latency instruction memory, buffers exactly one fetched instruction for the F/D register, and applies D-stage branch/jump redirects with delay-slot semantics.
- Handles CP0 flushes (exception/eret target) and raises AdEL on bad fetch addresses.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first fetch after reset.
- TEXT_LO, 32'h0000_3000, lowest legal instruction address.
- TEXT_HI, 32'h0000_6FFC, highest legal instruction address.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- D_stall  in  1  hazard-unit stall; F/D register holds while high.
- D_redirect  in  1  branch taken / jump in D; meaningful only when D_stall=0.
- D_target  in  32  redirect target (branch, jal or jr address).
- F_flush  in  1  CP0 flush request; highest priority.
- F_flush_pc  in  32  fetch address after a flush.
- imem_req  out  1  memory request, held until ack.
- imem_addr  out  32  request address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word.
- F_PC  out  32  address of the buffered instruction.
- F_Instr  out  32  buffered instruction.
- F_valid  out  1  buffer holds an instruction; F/D loads when F_valid & !D_stall.
- F_ExcAdEL  out  1  buffered entry is an address-error fetch.

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, npc=RESET_PC, F_PC=RESET_PC, F_Instr=0, F_valid=0, F_ExcAdEL=0, imem_req=0. Reset mid-transaction abandons the outstanding request; the memory model is reset with the same signal.
- consume = F_valid & !D_stall.
- Fetch depth is one ahead: a new request is issued only when the buffer is empty or is being consumed this cycle.
- issue_addr:
  - D_target if D_redirect & !D_stall this cycle (bypass);
  - otherwise npc.
- When an issue occurs: npc <= issue_addr + 4.
- Redirect accepted without an issue this cycle: npc <= D_target.
- Delay slot: when a branch enters D, its delay-slot fetch was already issued from branch PC+4, so the redirect changes only the fetch after the slot.
- bad = issue_addr[1:0] != 0, or issue_addr < TEXT_LO, or issue_addr > TEXT_HI.
  - A bad address is not sent to memory.
  - The buffer loads F_Instr=0, F_PC=issue_addr, F_ExcAdEL=1, F_valid=1 on the next edge.
- States:
  - IDLE: issue immediately. Bad address -> FULL. Otherwise imem_req=1: ack -> FULL, no ack -> REQ.
  - REQ: imem_req=1, imem_addr held stable. On ack: F_Instr=imem_rdata, F_PC=imem_addr, F_ExcAdEL=0, F_valid<=1 -> FULL.
  - FULL: F_valid=1. If consume, issue combinationally in the same cycle: ack -> stay FULL with the new word; no ack -> REQ with F_valid<=0; bad -> FULL with an AdEL entry. If no consume, hold everything.
  - DRAIN: imem_req=1 with the old address. On ack, discard the data -> IDLE.
- Throughput: a zero-wait memory sustains one instruction per cycle; the first F_valid appears 2 cycles after reset drops.
- Flush: F_flush overrides redirect, stall and consume.
  - F_valid<=0, npc<=F_flush_pc.
  - In REQ without ack this cycle -> DRAIN; otherwise -> IDLE.
  - Flush during DRAIN keeps DRAIN and updates npc.
- Simultaneous events:
  - flush beats redirect;
  - redirect with D_stall=1 is ignored (it is re-presented later);
  - ack coincident with flush in REQ: data is discarded -> IDLE.
- npc wraps modulo 2^32; the wrapped address fails the range check and raises AdEL.

Decomposition:
- Shared package holds:
  - the state encodings IDLE/REQ/FULL/DRAIN;
  - RESET_PC, TEXT_LO, TEXT_HI;
  - the CP0 AdEL ExcCode (4).
- One natural sub-module, f_addr_check: combinational range and alignment check producing `bad`.

Test Plan:
- Zero-wait memory (ack same cycle), D_stall=0 -> F_PC sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, F_valid continuous from cycle 2.
- Ack delayed 3 cycles per request -> F_valid pulses once every 4 cycles, imem_addr stable while imem_req=1.
- Branch at 0x3004 with D_redirect=1 and D_target=0x3100 one cycle after its consume -> fetch order 0x3004, 0x3008 (delay slot), 0x3100.
- D_stall=1 for 5 cycles with buffer FULL and D_redirect=1 asserted -> no new imem_req, npc unchanged; on stall release imem_addr=D_target in the same cycle.
- F_flush with F_flush_pc=0x4180 while REQ is outstanding and ack comes 2 cycles later -> DRAIN, stale data discarded, next imem_addr=0x4180, F_valid stays 0 until its ack.
- D_target=0x3102 (misaligned) and separately 0x7000 (out of range) -> no imem_req, F_valid=1, F_ExcAdEL=1, F_Instr=0, F_PC equal to the bad address.

Source files
------------

// File: rtl/f_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl_pkg
// Shared definitions for the MIPS fetch-stage sequencer:
//   - fetch_state_t : sequencer state encoding (IDLE/REQ/FULL/DRAIN)
//   - RESET_PC, TEXT_LO, TEXT_HI : default fetch address map
//   - exc_code_t    : CP0 ExcCode values raised by the fetch stage
//   - fetch_entry_t : contents of the single-entry fetch buffer
//   - fetch_addr_bad: alignment / text-range check helper
// ---------------------------------------------------------------------------
package f_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // buffer empty, nothing outstanding
        REQ   = 2'd1,   // request outstanding, buffer empty
        FULL  = 2'd2,   // buffer holds an instruction (or an AdEL entry)
        DRAIN = 2'd3    // flushed request still outstanding; its data is dropped
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4
    } exc_code_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc_adel;
    } fetch_entry_t;

    function automatic logic fetch_addr_bad(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage : f_fetch_ctrl_pkg

// File: rtl/f_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl_if
// Instruction-memory request/acknowledge bus.
//   imem_req   : request, held until acknowledged
//   imem_addr  : request address, stable while imem_req is high
//   imem_ack   : memory returns imem_rdata this cycle
//   imem_rdata : instruction word
// Modports: master = fetch sequencer, slave = instruction memory.
// ---------------------------------------------------------------------------
interface f_fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : f_fetch_ctrl_if

// File: rtl/f_fetch_ctrl_addr_check.sv
// ---------------------------------------------------------------------------
// f_addr_check
// Combinational fetch-address legality check.
//   addr : candidate fetch address
//   bad  : high when addr is not word aligned or lies outside
//          [TEXT_LO, TEXT_HI]
// ---------------------------------------------------------------------------
module f_addr_check
    import f_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] LO = TEXT_LO,
    parameter logic [31:0] HI = TEXT_HI
) (
    input  logic [31:0] addr,
    output logic        bad
);

    always_comb begin
        bad = fetch_addr_bad(addr, LO, HI);
    end

endmodule : f_addr_check

// File: rtl/f_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// f_fetch_ctrl
// Fetch-stage sequencer for the 5-stage MIPS pipeline. Owns the F-stage PC
// and the next-fetch address (npc), issues requests to a variable-latency
// instruction memory, buffers one fetched instruction for the F/D register,
// applies D-stage redirects (delay-slot semantics) and CP0 flushes, and turns
// illegal fetch addresses into AdEL buffer entries.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   D_stall      : F/D register holds while high
//   D_redirect   : taken branch / jump in D (ignored while D_stall)
//   D_target     : redirect target
//   F_flush      : CP0 flush, highest priority
//   F_flush_pc   : fetch address after a flush
//   imem         : instruction-memory bus (master side)
//   F_PC         : address of the buffered instruction
//   F_Instr      : buffered instruction (0 for an AdEL entry)
//   F_valid      : buffer holds an entry; F/D loads on F_valid & !D_stall
//   F_ExcAdEL    : buffered entry is an address-error fetch
// ---------------------------------------------------------------------------
module f_fetch_ctrl
    import f_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = f_fetch_ctrl_pkg::RESET_PC,
    parameter logic [31:0] TEXT_LO  = f_fetch_ctrl_pkg::TEXT_LO,
    parameter logic [31:0] TEXT_HI  = f_fetch_ctrl_pkg::TEXT_HI
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  D_stall,
    input  logic                  D_redirect,
    input  logic [31:0]           D_target,
    input  logic                  F_flush,
    input  logic [31:0]           F_flush_pc,
    f_fetch_ctrl_if.master        imem,
    output logic [31:0]           F_PC,
    output logic [31:0]           F_Instr,
    output logic                  F_valid,
    output logic                  F_ExcAdEL
);

    fetch_state_t state_q, state_d;
    logic [31:0]  npc_q, npc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    fetch_entry_t buf_q, buf_d;
    logic         valid_q, valid_d;

    logic         consume;
    logic         redirect_ok;
    logic         issue;
    logic [31:0]  issue_addr;
    logic         bad;

    // Issue decision. A redirect bypasses npc so the target goes out in the
    // same cycle the redirect is accepted.
    always_comb begin
        consume     = valid_q & ~D_stall;
        redirect_ok = D_redirect & ~D_stall & ~F_flush;
        issue_addr  = redirect_ok ? D_target : npc_q;
        issue       = ~F_flush & ((state_q == IDLE) | ((state_q == FULL) & consume));
    end

    f_addr_check #(
        .LO (TEXT_LO),
        .HI (TEXT_HI)
    ) u_addr_check (
        .addr (issue_addr),
        .bad  (bad)
    );

    // Memory-side outputs. Kept apart from the next-state logic so that
    // imem_req never depends on imem_ack, even through a shared process.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = issue_addr;
        unique case (state_q)
            IDLE, FULL: begin
                imem.imem_req = issue & ~bad;
            end
            REQ, DRAIN: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = req_addr_q;
            end
            default: ;
        endcase
        if (reset) begin
            imem.imem_req = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        npc_d      = npc_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        valid_d    = valid_q;

        if (F_flush) begin
            // An ack arriving together with the flush retires the old request
            // (data dropped); otherwise it is still in flight and must drain.
            valid_d = 1'b0;
            npc_d   = F_flush_pc;
            if (((state_q == REQ) || (state_q == DRAIN)) && !imem.imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end else if (issue) begin
            npc_d = issue_addr + 32'd4;
            if (bad) begin
                buf_d   = '{pc: issue_addr, instr: '0, exc_adel: 1'b1};
                valid_d = 1'b1;
                state_d = FULL;
            end else if (imem.imem_ack) begin
                buf_d   = '{pc: issue_addr, instr: imem.imem_rdata, exc_adel: 1'b0};
                valid_d = 1'b1;
                state_d = FULL;
            end else begin
                req_addr_d = issue_addr;
                valid_d    = 1'b0;
                state_d    = REQ;
            end
        end else begin
            // The outstanding fetch is the delay slot, so an accepted redirect
            // only retargets the fetch after it.
            if (redirect_ok) begin
                npc_d = D_target;
            end
            unique case (state_q)
                REQ: begin
                    if (imem.imem_ack) begin
                        buf_d   = '{pc: req_addr_q, instr: imem.imem_rdata, exc_adel: 1'b0};
                        valid_d = 1'b1;
                        state_d = FULL;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            npc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= '{pc: RESET_PC, instr: '0, exc_adel: 1'b0};
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            npc_q      <= npc_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        F_PC      = buf_q.pc;
        F_Instr   = buf_q.instr;
        F_ExcAdEL = buf_q.exc_adel;
        F_valid   = valid_q;
    end

endmodule : f_fetch_ctrl
